// File: rtl/leitor_fila.sv
// leitor_fila: drain-side controller for the 8-bit byte queue.
// Pops one byte at a time and shifts it out bit by bit over a valid/ready serial line.
module leitor_fila #(
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic [2:0] len_in,
  input  logic [7:0] data_in,
  input  logic       ready_in,
  output logic       dequeue_out,
  output logic       serial_out,
  output logic       valid_out,
  output logic       byte_done_out,
  output logic       busy_out,
  output logic [7:0] count_out
);

  // state | meaning
  // IDLE  | waiting for a non-empty queue (len_in != 0)
  // POP   | single-cycle dequeue request to the queue
  // WAIT  | queue output settling; shift register loads on exit
  // SHIFT | presenting one bit per accepted handshake
  // DONE  | byte_done pulse; count_out already holds the new total
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       accept;

  assign accept = (state == SHIFT) && ready_in;

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= 8'd0;
      bit_cnt   <= 3'd0;
      count_out <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == WAIT) begin
        shift_reg <= data_in;
        bit_cnt   <= 3'd0;
      end else if (accept) begin
        shift_reg <= MSB_FIRST ? {shift_reg[6:0], 1'b0} : {1'b0, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          count_out <= count_out + 8'd1;
        end
      end
    end
  end

  // Outputs decode the registered state only, so ready_in/len_in never reach a port.
  always_comb begin
    state_nxt     = state;
    dequeue_out   = 1'b0;
    valid_out     = 1'b0;
    serial_out    = 1'b1;
    byte_done_out = 1'b0;
    busy_out      = 1'b1;
    unique case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (len_in != 3'd0) begin
          state_nxt = POP;
        end
      end
      POP: begin
        dequeue_out = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        valid_out  = 1'b1;
        serial_out = MSB_FIRST ? shift_reg[7] : shift_reg[0];
        if (accept && (bit_cnt == 3'd7)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        byte_done_out = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_leitor_fila.sv
// Testbench for leitor_fila: both bit orders side by side, fed from a behavioural queue,
// with a per-cycle scoreboard derived from the byte values and handshake timing rules.
`timescale 1us/1ns
module tb_leitor_fila;

  logic       clk_10KHz = 1'b0;
  logic       reset;
  logic [2:0] len_in;
  logic [7:0] data_in;
  logic       ready_in;
  logic [1:0] dq, ser, val, done, busy;
  logic [7:0] cnt0, cnt1;

  always #50 clk_10KHz = ~clk_10KHz;

  leitor_fila #(.MSB_FIRST(1'b1)) dut_msb (
    .clk_10KHz(clk_10KHz), .reset(reset), .len_in(len_in), .data_in(data_in),
    .ready_in(ready_in), .dequeue_out(dq[0]), .serial_out(ser[0]), .valid_out(val[0]),
    .byte_done_out(done[0]), .busy_out(busy[0]), .count_out(cnt0)
  );

  leitor_fila #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk_10KHz(clk_10KHz), .reset(reset), .len_in(len_in), .data_in(data_in),
    .ready_in(ready_in), .dequeue_out(dq[1]), .serial_out(ser[1]), .valid_out(val[1]),
    .byte_done_out(done[1]), .busy_out(busy[1]), .count_out(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_10KHz) cyc++;

  // Queue model: pops on dequeue_out at the edge, len_in reports the pre-edge occupancy.
  logic [7:0] q[$];
  bit         qm_pend;
  int         qm_sz;
  initial begin
    len_in  = 3'd0;
    data_in = 8'd0;
    forever begin
      @(negedge clk_10KHz);
      qm_pend = dq[0];
      qm_sz   = q.size();
      @(posedge clk_10KHz);
      #1;
      if (qm_pend && q.size() > 0) data_in = q.pop_front();
      len_in = qm_sz[2:0];
    end
  end

  // Scoreboard
  bit         mon_en = 1'b0;
  bit         rst_prev = 1'b0;
  logic [7:0] cur_byte [2];
  int         nbits [2];
  int         exp_cnt [2];
  int         last_pop [2];
  int         pop_gap [2];
  int         done_cyc [2];
  int         stalls [2];
  int         n_pops [2];
  int         n_done [2];
  logic       prev_ser [2];
  bit         prev_stall [2];
  bit         prev_val [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      cur_byte[d] = 8'd0; nbits[d] = 0; exp_cnt[d] = 0; last_pop[d] = -1;
      pop_gap[d] = 0; done_cyc[d] = 0; stalls[d] = 0; n_pops[d] = 0; n_done[d] = 0;
      prev_ser[d] = 1'b1; prev_stall[d] = 1'b0; prev_val[d] = 1'b0;
    end
  end

  always @(negedge clk_10KHz) begin : mon
    int   c;
    logic e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        c = (d == 0) ? int'(cnt0) : int'(cnt1);
        if (rst_prev) begin
          check("rst_dequeue", dq[d], 0);
          check("rst_serial", ser[d], 1);
          check("rst_valid", val[d], 0);
          check("rst_done", done[d], 0);
          check("rst_busy", busy[d], 0);
          check("rst_count", c, 0);
          nbits[d] = 0; exp_cnt[d] = 0; last_pop[d] = -1; stalls[d] = 0;
        end else begin
          if (!val[d]) check("idle_serial_high", ser[d], 1);
          if (prev_stall[d] && val[d]) check("stall_hold", ser[d], prev_ser[d]);
          if (dq[d]) begin
            n_pops[d]++;
            check("pop_nonempty", int'(q.size() > 0), 1);
            if (last_pop[d] >= 0) begin
              pop_gap[d] = cyc - last_pop[d];
              check("pop_spacing", int'(pop_gap[d] >= 12), 1);
            end
            cur_byte[d] = (q.size() > 0) ? q[0] : 8'd0;
            last_pop[d] = cyc; nbits[d] = 0; stalls[d] = 0;
          end
          if (val[d]) begin
            if (nbits[d] == 0 && !prev_val[d]) check("first_bit_latency", cyc - last_pop[d], 2);
            if (ready_in && !reset) begin
              e = (d == 0) ? cur_byte[d][7 - nbits[d]] : cur_byte[d][nbits[d]];
              check(d == 0 ? "stream_bit_msb" : "stream_bit_lsb", ser[d], e);
              nbits[d]++;
            end else if (!ready_in) begin
              stalls[d]++;
            end
          end
          if (done[d]) begin
            n_done[d]++;
            done_cyc[d] = cyc;
            exp_cnt[d] = (exp_cnt[d] + 1) % 256;
            check("done_bits", nbits[d], 8);
            check("done_latency", cyc - last_pop[d], 10 + stalls[d]);
            nbits[d] = 0;
          end
          check("count", c, exp_cnt[d]);
        end
        prev_ser[d]   = ser[d];
        prev_val[d]   = val[d];
        prev_stall[d] = val[d] && !ready_in && !reset;
      end
    end
    rst_prev = reset;
  end

  task automatic do_reset();
    @(posedge clk_10KHz); #1;
    reset = 1'b1; ready_in = 1'b1;
    repeat (2) @(posedge clk_10KHz);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int stable = 0;
    for (int i = 0; i < budget && stable < 3; i++) begin
      @(negedge clk_10KHz);
      if (q.size() == 0 && len_in == 3'd0 && !busy[0] && !busy[1]) stable++;
      else stable = 0;
    end
    check("drain_within_budget", int'(stable >= 3), 1);
  endtask

  task automatic wait_pop(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_10KHz);
      seen = dq[0];
    end
    check("pop_within_budget", int'(seen), 1);
  endtask

  int p0, d0, pushed;
  logic [7:0] bv;

  initial begin
    reset    = 1'b1;
    ready_in = 1'b1;
    // Reset with a non-empty queue: no pop until reset is released.
    for (int i = 0; i < 3; i++) begin
      bv = 8'($urandom_range(0, 255));
      q.push_back(bv);
    end
    @(posedge clk_10KHz); #1 mon_en = 1'b1;
    @(posedge clk_10KHz); #1 reset = 1'b0;
    @(negedge clk_10KHz);
    check("no_pop_in_reset", dq[0], 0);
    check("len_seen_during_reset", len_in, 3);
    @(negedge clk_10KHz);
    check("first_pop_after_reset_msb", dq[0], 1);
    check("first_pop_after_reset_lsb", dq[1], 1);
    wait_idle(200);
    check("reset_case_pops", n_pops[0], 3);
    check("reset_case_done", n_done[1], 3);

    // Single byte 0xA5
    do_reset();
    p0 = n_pops[0]; d0 = n_done[0];
    q.push_back(8'hA5);
    wait_idle(100);
    check("single_pops", n_pops[0] - p0, 1);
    check("single_done", n_done[0] - d0, 1);
    check("single_count", cnt0, 1);

    // Stall: ready low in cycles 5..7 relative to the pop cycle
    do_reset();
    q.push_back(8'hA5);
    wait_pop(50);
    repeat (4) @(posedge clk_10KHz);
    #1 ready_in = 1'b0;
    repeat (3) @(posedge clk_10KHz);
    #1 ready_in = 1'b1;
    @(negedge clk_10KHz);
    check("stall_bit2_held", ser[0], 1);
    wait_idle(100);
    check("stall_done_cycle", done_cyc[0] - last_pop[0], 13);
    check("stall_done_cycle_lsb", done_cyc[1] - last_pop[1], 13);

    // Back-to-back 0x3C, 0xC3
    do_reset();
    p0 = n_pops[0];
    q.push_back(8'h3C);
    q.push_back(8'hC3);
    wait_idle(100);
    check("b2b_pops", n_pops[0] - p0, 2);
    check("b2b_gap", pop_gap[0], 12);
    check("b2b_count", cnt0, 2);

    // Reset in cycle 6 of a 0xFF transfer
    do_reset();
    p0 = n_pops[0]; d0 = n_done[0];
    q.push_back(8'hFF);
    wait_pop(50);
    repeat (5) @(posedge clk_10KHz);
    #1 reset = 1'b1;
    @(posedge clk_10KHz);
    #1 reset = 1'b0;
    @(negedge clk_10KHz);
    check("midreset_serial", ser[0], 1);
    check("midreset_valid", val[0], 0);
    check("midreset_busy", busy[0], 0);
    check("midreset_count", cnt0, 0);
    wait_idle(40);
    check("midreset_no_done", n_done[0] - d0, 0);
    check("midreset_no_repop", n_pops[0] - p0, 1);

    // Random traffic with random back-pressure
    do_reset();
    p0 = n_pops[0]; d0 = n_done[1]; pushed = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk_10KHz); #1;
      ready_in = ($urandom_range(0, 3) != 0);
      if (q.size() < 7 && $urandom_range(0, 9) == 0) begin
        bv = 8'($urandom_range(0, 255));
        q.push_back(bv);
        pushed++;
      end
    end
    @(posedge clk_10KHz); #1 ready_in = 1'b1;
    wait_idle(200);
    check("rand_pops", n_pops[0] - p0, pushed);
    check("rand_done", n_done[1] - d0, pushed);

    // 256 bytes: count wraps to 0; first byte 0x01 exercises LSB order
    do_reset();
    d0 = n_done[1]; pushed = 0;
    q.push_back(8'h01);
    pushed = 1;
    while (pushed < 256) begin
      @(posedge clk_10KHz); #1;
      if (q.size() < 7) begin
        bv = 8'($urandom_range(0, 255));
        q.push_back(bv);
        pushed++;
      end
    end
    wait_idle(4000);
    check("wrap_done", n_done[1] - d0, 256);
    check("wrap_count_msb", cnt0, 0);
    check("wrap_count_lsb", cnt1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
